// File: rtl/vga_timing_gen_if.sv
// ---------------------------------------------------------------------------
// vga_timing_gen_if
//   Bundle of timing outputs from vga_timing_gen to the downstream pixel
//   pipeline.
//   master : driven by the timing generator
//   slave  : consumed by the pixel pipeline
//   Signals: ready, pix_ce, hsync, vsync, active, x[10:0], y[9:0],
//            frame_start, rgb[11:0] (only with VGA_TEST_PATTERN_EN)
// ---------------------------------------------------------------------------
interface vga_timing_gen_if;
    logic        ready;
    logic        pix_ce;
    logic        hsync;
    logic        vsync;
    logic        active;
    logic [10:0] x;
    logic [9:0]  y;
    logic        frame_start;
`ifdef VGA_TEST_PATTERN_EN
    logic [11:0] rgb;

    modport master (output ready, pix_ce, hsync, vsync, active, x, y, frame_start, rgb);
    modport slave  (input  ready, pix_ce, hsync, vsync, active, x, y, frame_start, rgb);
`else
    modport master (output ready, pix_ce, hsync, vsync, active, x, y, frame_start);
    modport slave  (input  ready, pix_ce, hsync, vsync, active, x, y, frame_start);
`endif
endinterface

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//   Pixel-timing stage running on the PLL output clock. Start-up is gated
//   on a synchronised, filtered PLL lock; once running, a 1-in-CLK_DIV
//   pixel enable steps the h/v counters and the registered VGA decode.
//   Optional macro: VGA_TEST_PATTERN_EN adds an 8-bar colour test pattern
//   on vga.rgb.
//   Ports:
//     clock_in : PLL output clock
//     reset    : async active-high reset
//     locked   : PLL lock flag, asynchronous to clock_in
//     vga      : vga_timing_gen_if.master (ready, pix_ce, hsync, vsync,
//                active, x, y, frame_start[, rgb])
// ---------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int CLK_DIV     = 6,
    parameter int LOCK_FILTER = 1024,
    parameter int H_ACTIVE    = 800,
    parameter int H_FP        = 40,
    parameter int H_SYNC      = 128,
    parameter int H_BP        = 88,
    parameter int V_ACTIVE    = 600,
    parameter int V_FP        = 1,
    parameter int V_SYNC      = 4,
    parameter int V_BP        = 23,
    parameter bit HS_POL      = 1'b1,
    parameter bit VS_POL      = 1'b1
) (
    input  logic             clock_in,
    input  logic             reset,
    input  logic             locked,
    vga_timing_gen_if.master vga
);

    localparam int DIV_W  = $clog2(CLK_DIV);
    localparam int FILT_W = $clog2(LOCK_FILTER + 1);

    typedef logic [10:0]       h_t;
    typedef logic [9:0]        v_t;
    typedef logic [DIV_W-1:0]  div_t;
    typedef logic [FILT_W-1:0] filt_t;

    localparam h_t    H_LAST   = h_t'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam h_t    H_ACT    = h_t'(H_ACTIVE);
    localparam h_t    HS_START = h_t'(H_ACTIVE + H_FP);
    localparam h_t    HS_END   = h_t'(H_ACTIVE + H_FP + H_SYNC);
    localparam v_t    V_LAST   = v_t'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam v_t    V_ACT    = v_t'(V_ACTIVE);
    localparam v_t    VS_START = v_t'(V_ACTIVE + V_FP);
    localparam v_t    VS_END   = v_t'(V_ACTIVE + V_FP + V_SYNC);
    localparam div_t  DIV_LAST = div_t'(CLK_DIV - 1);
    localparam filt_t FILT_LAST = filt_t'(LOCK_FILTER - 1);

`ifdef VGA_TEST_PATTERN_EN
    localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
    // White, yellow, cyan, green, magenta, red, blue, black.
    localparam logic [11:0] BAR_RGB [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                                            12'hF0F, 12'hF00, 12'h00F, 12'h000};
`endif

    typedef enum logic [1:0] {WAIT_LOCK, SETTLE, RUN} state_t;

    // Everything the pixel pipeline sees for one pixel, registered together.
    typedef struct packed {
        logic        active;
        logic        hsync;
        logic        vsync;
        logic        frame_start;
`ifdef VGA_TEST_PATTERN_EN
        logic [11:0] rgb;
`endif
    } dec_t;

    function automatic dec_t idle_dec();
        dec_t d;
        d.active      = 1'b0;
        d.hsync       = ~HS_POL;
        d.vsync       = ~VS_POL;
        d.frame_start = 1'b0;
`ifdef VGA_TEST_PATTERN_EN
        d.rgb         = 12'h000;
`endif
        return d;
    endfunction

`ifdef VGA_TEST_PATTERN_EN
    // Bar index = number of bar boundaries at or left of h (clamped to 7).
    function automatic logic [11:0] bar_colour(input h_t h);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (h >= h_t'(i * BAR_W)) idx = 3'(i);
        end
        return BAR_RGB[idx];
    endfunction
`endif

    function automatic dec_t decode(input h_t h, input v_t v);
        dec_t d;
        d.active      = (h < H_ACT) && (v < V_ACT);
        d.hsync       = (h >= HS_START && h < HS_END) ? HS_POL : ~HS_POL;
        d.vsync       = (v >= VS_START && v < VS_END) ? VS_POL : ~VS_POL;
        d.frame_start = (h == '0) && (v == '0);
`ifdef VGA_TEST_PATTERN_EN
        d.rgb         = d.active ? bar_colour(h) : 12'h000;
`endif
        return d;
    endfunction

    // Two-flop synchroniser; lock_s_q is the only form of locked used below.
    logic lock_meta_q, lock_s_q;

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make both flops sample their
            // old values on the same edge, forming a true two-stage chain.
            lock_meta_q <= locked;
            lock_s_q    <= lock_meta_q;
        end
    end

    state_t state_q, state_d;
    filt_t  filt_q,  filt_d;
    div_t   div_q,   div_d;
    h_t     h_q,     h_d;
    v_t     v_q,     v_d;
    dec_t   dec_q,   dec_d;
    logic   pix_ce_q, pix_ce_d;
    logic   ready_q,  ready_d;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d  = state_q;
        filt_d   = filt_q;
        div_d    = div_q;
        h_d      = h_q;
        v_d      = v_q;
        dec_d    = dec_q;
        pix_ce_d = 1'b0;

        unique case (state_q)
            WAIT_LOCK: begin
                if (lock_s_q) begin
                    state_d = SETTLE;
                    filt_d  = '0;
                end
            end
            SETTLE: begin
                if (!lock_s_q) begin
                    state_d = WAIT_LOCK;
                end else if (filt_q == FILT_LAST) begin
                    // Enter RUN already presenting pixel (0,0).
                    state_d = RUN;
                    div_d   = '0;
                    h_d     = '0;
                    v_d     = '0;
                    dec_d   = decode('0, '0);
                end else begin
                    filt_d = filt_q + 1'b1;
                end
            end
            RUN: begin
                if (!lock_s_q) begin
                    state_d = WAIT_LOCK;
                end else begin
                    div_d    = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
                    pix_ce_d = (div_d == DIV_LAST);
                    // pix_ce_q is high in the last cycle of a pixel; this
                    // edge moves to the next pixel.
                    if (pix_ce_q) begin
                        if (h_q == H_LAST) begin
                            h_d = '0;
                            v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
                        end else begin
                            h_d = h_q + 11'd1;
                        end
                        dec_d = decode(h_d, v_d);
                    end
                end
            end
            default: state_d = WAIT_LOCK;
        endcase

        // Any entry to WAIT_LOCK returns all outputs to their reset values
        // on the same edge, keeping lock-loss response at three cycles.
        if (state_d == WAIT_LOCK) begin
            filt_d   = '0;
            div_d    = '0;
            h_d      = '0;
            v_d      = '0;
            dec_d    = idle_dec();
            pix_ce_d = 1'b0;
        end

        ready_d = (state_d == RUN);
    end

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            state_q  <= WAIT_LOCK;
            filt_q   <= '0;
            div_q    <= '0;
            h_q      <= '0;
            v_q      <= '0;
            dec_q    <= idle_dec();
            pix_ce_q <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            filt_q   <= filt_d;
            div_q    <= div_d;
            h_q      <= h_d;
            v_q      <= v_d;
            dec_q    <= dec_d;
            pix_ce_q <= pix_ce_d;
            ready_q  <= ready_d;
        end
    end

    assign vga.ready       = ready_q;
    assign vga.pix_ce      = pix_ce_q;
    assign vga.hsync       = dec_q.hsync;
    assign vga.vsync       = dec_q.vsync;
    assign vga.active      = dec_q.active;
    assign vga.x           = h_q;
    assign vga.y           = v_q;
    assign vga.frame_start = dec_q.frame_start;
`ifdef VGA_TEST_PATTERN_EN
    assign vga.rgb         = dec_q.rgb;
`endif

endmodule
